psramc_init_mst: RTL and testbench

Boot-time bus initiator for the PSRAM controller register file, on the mem_valid/mem_ready bus that register file responds to. On a start pulse it programs the timing register (TR), enables the controller through CR with a clock divider, and polls SR until the device reports ready. It then reads ID0 and CR0 back and optionally writes a new CR0 using the complement-guarded format. It sits between the SoC reset/boot logic and psramc_reg, so firmware never needs to bring up the memory.

---
 rtl/psramc_pkg.sv | 34 +++
 rtl/psramc_init_mst_if.sv | 29 ++
 rtl/psramc_mst_xfer.sv | 60 ++++++
 rtl/psramc_init_mst.sv | 213 +++++++++++++++++++++
 tb/tb_psramc_init_mst.sv | 303 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/psramc_pkg.sv
// Shared register map, status bits, error codes and FSM encodings for the
// PSRAM controller boot initiator.
package psramc_pkg;

   localparam logic [11:0] ADDR_CR  = 12'h000;
   localparam logic [11:0] ADDR_SR  = 12'h004;
   localparam logic [11:0] ADDR_TR  = 12'h008;
   localparam logic [11:0] ADDR_ID0 = 12'h00C;
   localparam logic [11:0] ADDR_ID1 = 12'h010;
   localparam logic [11:0] ADDR_CR0 = 12'h014;
   localparam logic [11:0] ADDR_CR1 = 12'h018;

   localparam int unsigned SR_READY = 0;
   localparam int unsigned SR_ERROR = 1;

   typedef logic [1:0] err_code_t;
   localparam err_code_t ERR_NONE = 2'd0;
   localparam err_code_t ERR_BUS  = 2'd1;
   localparam err_code_t ERR_DEV  = 2'd2;
   localparam err_code_t ERR_POLL = 2'd3;

   typedef logic [3:0] state_t;
   localparam state_t ST_IDLE   = 4'd0;
   localparam state_t ST_WR_TR  = 4'd1;
   localparam state_t ST_WR_CR  = 4'd2;
   localparam state_t ST_RD_SR  = 4'd3;
   localparam state_t ST_GAP    = 4'd4;
   localparam state_t ST_RD_ID0 = 4'd5;
   localparam state_t ST_RD_CR0 = 4'd6;
   localparam state_t ST_WR_CR0 = 4'd7;
   localparam state_t ST_DONE   = 4'd8;
   localparam state_t ST_ERR    = 4'd9;

endpackage

// File: rtl/psramc_init_mst_if.sv
// mem_valid/mem_ready register bus between the boot initiator and psramc_reg.
interface psramc_init_mst_if;

   logic        mem_valid;
   logic        mem_ready;
   logic [11:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [3:0]  mem_wstrb;
   logic [31:0] mem_rdata;

   modport master (
      output mem_valid,
      output mem_addr,
      output mem_wdata,
      output mem_wstrb,
      input  mem_ready,
      input  mem_rdata
   );

   modport slave (
      input  mem_valid,
      input  mem_addr,
      input  mem_wdata,
      input  mem_wstrb,
      output mem_ready,
      output mem_rdata
   );

endinterface

// File: rtl/psramc_mst_xfer.sv
// Single-transaction engine: launches one registered request, waits for the
// ready strobe and aborts after BUS_TO cycles without one.
module psramc_mst_xfer #(
   parameter int unsigned BUS_TO = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req,
   input  logic [11:0] addr,
   input  logic [31:0] wdata,
   input  logic        write,
   output logic        ack,
   output logic [31:0] rdata,
   output logic        timeout,
   psramc_init_mst_if.master bus
);

   localparam int unsigned TW = $clog2(BUS_TO) + 1;
   localparam logic [TW-1:0] TO_LAST = TW'(BUS_TO - 1);

   logic          valid_q;
   logic [11:0]   addr_q;
   logic [31:0]   wdata_q;
   logic [3:0]    wstrb_q;
   logic [TW-1:0] to_cnt_q;

   assign ack     = valid_q & bus.mem_ready;
   assign timeout = valid_q & ~bus.mem_ready & (to_cnt_q == TO_LAST);
   assign rdata   = bus.mem_rdata;

   // A request is only accepted while idle, so the cycle that completes a
   // transfer can never relaunch it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         valid_q  <= 1'b0;
         addr_q   <= '0;
         wdata_q  <= '0;
         wstrb_q  <= '0;
         to_cnt_q <= '0;
      end else if (!valid_q) begin
         if (req) begin
            valid_q  <= 1'b1;
            addr_q   <= addr;
            wdata_q  <= wdata;
            wstrb_q  <= {4{write}};
            to_cnt_q <= '0;
         end
      end else if (ack || timeout) begin
         valid_q <= 1'b0;
      end else begin
         to_cnt_q <= to_cnt_q + TW'(1);
      end
   end

   assign bus.mem_valid = valid_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign bus.mem_wstrb = wstrb_q;

endmodule

// File: rtl/psramc_init_mst.sv
// Boot-time initiator: programs TR and CR, polls SR until ready, reads back
// ID0/CR0 and optionally rewrites CR0 in complement-guarded form.
module psramc_init_mst
   import psramc_pkg::*;
#(
   parameter logic [31:0] TR_VAL   = 32'h0432_220A,
   parameter logic [3:0]  CKDIV    = 4'd3,
   parameter logic [15:0] CR0_VAL  = 16'h8F1F,
   parameter bit          WR_CR0   = 1'b1,
   parameter int unsigned POLL_GAP = 16,
   parameter int unsigned POLL_MAX = 1024,
   parameter int unsigned BUS_TO   = 64
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        start,
   psramc_init_mst_if.master bus,
   output logic        busy,
   output logic        done,
   output logic        err,
   output logic [1:0]  err_code,
   output logic [15:0] id0,
   output logic [15:0] cr0
);

   localparam int unsigned PW = $clog2(POLL_MAX) + 1;
   localparam int unsigned GW = $clog2(POLL_GAP) + 1;
   localparam logic [PW-1:0] POLL_LAST = PW'(POLL_MAX);
   localparam logic [GW-1:0] GAP_LAST  = GW'(POLL_GAP - 1);

   state_t        state_q, state_d;
   logic [PW-1:0] poll_q, poll_d;
   logic [GW-1:0] gap_q, gap_d;
   logic          busy_q, busy_d;
   logic          done_q, done_d;
   logic          err_q, err_d;
   err_code_t     code_q, code_d;
   logic [15:0]   id0_q, id0_d;
   logic [15:0]   cr0_q, cr0_d;

   logic        req;
   logic [11:0] addr;
   logic [31:0] wdata;
   logic        write;
   logic        ack;
   logic        timeout;
   logic [31:0] rdata;
   logic        unused_rdata_hi;

   assign unused_rdata_hi = ^rdata[31:16];

   psramc_mst_xfer #(
      .BUS_TO (BUS_TO)
   ) u_xfer (
      .clk     (clk),
      .rst_n   (rst_n),
      .req     (req),
      .addr    (addr),
      .wdata   (wdata),
      .write   (write),
      .ack     (ack),
      .rdata   (rdata),
      .timeout (timeout),
      .bus     (bus)
   );

   always_comb begin
      req   = 1'b1;
      write = 1'b0;
      addr  = '0;
      wdata = '0;
      case (state_q)
         ST_WR_TR: begin
            addr  = ADDR_TR;
            wdata = TR_VAL;
            write = 1'b1;
         end
         ST_WR_CR: begin
            addr  = ADDR_CR;
            wdata = {24'b0, CKDIV, 3'b0, 1'b1};
            write = 1'b1;
         end
         ST_RD_SR:  addr = ADDR_SR;
         ST_RD_ID0: addr = ADDR_ID0;
         ST_RD_CR0: addr = ADDR_CR0;
         ST_WR_CR0: begin
            addr  = ADDR_CR0;
            wdata = {~CR0_VAL, CR0_VAL};
            write = 1'b1;
         end
         default: req = 1'b0;
      endcase
   end

   always_comb begin
      state_d = state_q;
      poll_d  = poll_q;
      gap_d   = gap_q;
      busy_d  = busy_q;
      done_d  = done_q;
      err_d   = err_q;
      code_d  = code_q;
      id0_d   = id0_q;
      cr0_d   = cr0_q;
      if (timeout) begin
         state_d = ST_ERR;
         busy_d  = 1'b0;
         err_d   = 1'b1;
         code_d  = ERR_BUS;
      end else begin
         case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
               if (start) begin
                  state_d = ST_WR_TR;
                  busy_d  = 1'b1;
                  done_d  = 1'b0;
                  err_d   = 1'b0;
                  code_d  = ERR_NONE;
                  poll_d  = '0;
               end
            end
            ST_WR_TR: if (ack) state_d = ST_WR_CR;
            ST_WR_CR: if (ack) state_d = ST_RD_SR;
            ST_RD_SR: begin
               if (ack) begin
                  // The device error bit outranks the ready bit.
                  if (rdata[SR_ERROR]) begin
                     state_d = ST_ERR;
                     busy_d  = 1'b0;
                     err_d   = 1'b1;
                     code_d  = ERR_DEV;
                  end else if (rdata[SR_READY]) begin
                     state_d = ST_RD_ID0;
                  end else begin
                     poll_d = poll_q + PW'(1);
                     if (poll_d == POLL_LAST) begin
                        state_d = ST_ERR;
                        busy_d  = 1'b0;
                        err_d   = 1'b1;
                        code_d  = ERR_POLL;
                     end else begin
                        state_d = ST_GAP;
                        gap_d   = '0;
                     end
                  end
               end
            end
            ST_GAP: begin
               gap_d = gap_q + GW'(1);
               if (gap_q == GAP_LAST) state_d = ST_RD_SR;
            end
            ST_RD_ID0: begin
               if (ack) begin
                  id0_d   = rdata[15:0];
                  state_d = ST_RD_CR0;
               end
            end
            ST_RD_CR0: begin
               if (ack) begin
                  cr0_d = rdata[15:0];
                  if (WR_CR0) begin
                     state_d = ST_WR_CR0;
                  end else begin
                     state_d = ST_DONE;
                     busy_d  = 1'b0;
                     done_d  = 1'b1;
                  end
               end
            end
            ST_WR_CR0: begin
               if (ack) begin
                  state_d = ST_DONE;
                  busy_d  = 1'b0;
                  done_d  = 1'b1;
               end
            end
            default: state_d = ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         poll_q  <= '0;
         gap_q   <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
         code_q  <= ERR_NONE;
         id0_q   <= '0;
         cr0_q   <= '0;
      end else begin
         state_q <= state_d;
         poll_q  <= poll_d;
         gap_q   <= gap_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         err_q   <= err_d;
         code_q  <= code_d;
         id0_q   <= id0_d;
         cr0_q   <= cr0_d;
      end
   end

   assign busy     = busy_q;
   assign done     = done_q;
   assign err      = err_q;
   assign err_code = code_q;
   assign id0      = id0_q;
   assign cr0      = cr0_q;

endmodule

// File: tb/tb_psramc_init_mst.sv
// Bench for psramc_init_mst: two instances (default and WR_CR0=0/POLL_MAX=4)
// against a small register-file responder, with a transaction scoreboard.
module tb_psramc_init_mst;
   import psramc_pkg::*;

   localparam logic [31:0] CR0_RB = 32'h0000_8F2F;

   typedef struct packed {
      logic [11:0] addr;
      logic [3:0]  wstrb;
      logic [31:0] wdata;
   } txn_t;

   typedef struct {
      int          dut;
      int          not_rdy;
      logic        sr_err;
      logic        stall;
      logic [15:0] id0v;
      logic        exp_done;
      logic        exp_err;
      logic [1:0]  exp_code;
      int          n_setup;
      int          n_sr;
      logic        tail;
      logic        cr0w;
   } vec_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic [1:0]  start_v = '0;
   logic [1:0]  stall_v = '0;
   logic [1:0]  srerr_v = '0;
   int          rdy_after [2] = '{0, 0};
   logic [15:0] id0_model [2] = '{16'h0, 16'h0};

   logic [1:0]  busy_w, done_w, err_w;
   logic [1:0]  code_w [2];
   logic [15:0] id0_w [2];
   logic [15:0] cr0_w [2];

   psramc_init_mst_if bus_a ();
   psramc_init_mst_if bus_b ();

   psramc_init_mst dut_a (
      .clk (clk), .rst_n (rst_n), .start (start_v[0]), .bus (bus_a),
      .busy (busy_w[0]), .done (done_w[0]), .err (err_w[0]), .err_code (code_w[0]),
      .id0 (id0_w[0]), .cr0 (cr0_w[0])
   );

   psramc_init_mst #(
      .WR_CR0 (1'b0), .POLL_MAX (4)
   ) dut_b (
      .clk (clk), .rst_n (rst_n), .start (start_v[1]), .bus (bus_b),
      .busy (busy_w[1]), .done (done_w[1]), .err (err_w[1]), .err_code (code_w[1]),
      .id0 (id0_w[1]), .cr0 (cr0_w[1])
   );

   logic [1:0]  valid_w, ready_w;
   logic [11:0] addr_w [2];
   logic [31:0] wdata_w [2];
   logic [3:0]  wstrb_w [2];
   assign valid_w = {bus_b.mem_valid, bus_a.mem_valid};
   assign ready_w = {bus_b.mem_ready, bus_a.mem_ready};
   assign addr_w[0] = bus_a.mem_addr;
   assign addr_w[1] = bus_b.mem_addr;
   assign wdata_w[0] = bus_a.mem_wdata;
   assign wdata_w[1] = bus_b.mem_wdata;
   assign wstrb_w[0] = bus_a.mem_wstrb;
   assign wstrb_w[1] = bus_b.mem_wstrb;

   // Responder: ready one cycle after valid is seen, SR ready after a set number of reads.
   int n_sr [2] = '{0, 0};
   logic [31:0] sr_word [2];
   always_comb begin
      for (int i = 0; i < 2; i++) sr_word[i] = {30'b0, srerr_v[i], n_sr[i] > rdy_after[i]};
   end

   function automatic logic [31:0] rd_data(input logic [11:0] a, input logic [31:0] sr,
                                           input logic [15:0] id);
      case (a)
         ADDR_SR:  return sr;
         ADDR_ID0: return {16'h0, id};
         ADDR_CR0: return CR0_RB;
         default:  return 32'h0;
      endcase
   endfunction

   assign bus_a.mem_rdata = rd_data(bus_a.mem_addr, sr_word[0], id0_model[0]);
   assign bus_b.mem_rdata = rd_data(bus_b.mem_addr, sr_word[1], id0_model[1]);

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bus_a.mem_ready <= 1'b0;
         bus_b.mem_ready <= 1'b0;
      end else begin
         bus_a.mem_ready <= bus_a.mem_valid && !bus_a.mem_ready && !stall_v[0];
         bus_b.mem_ready <= bus_b.mem_valid && !bus_b.mem_ready && !stall_v[1];
      end
   end

   // Monitor: logs every completed transfer and the length of valid-high runs.
   int   cyc = 0;
   int   n_log [2] = '{0, 0};
   txn_t log_txn [2][64];
   int   log_rise [2][64];
   int   log_end [2][64];
   int   rise_cyc [2] = '{0, 0};
   int   hi_run [2] = '{0, 0};
   int   last_hi [2] = '{0, 0};

   always @(negedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 2; i++) begin
         if (valid_w[i]) begin
            hi_run[i] <= hi_run[i] + 1;
            if (hi_run[i] == 0) rise_cyc[i] <= cyc;
         end else if (hi_run[i] != 0) begin
            last_hi[i] <= hi_run[i];
            hi_run[i]  <= 0;
         end
         if (valid_w[i] && ready_w[i] && n_log[i] < 64) begin
            log_txn[i][n_log[i]]  <= txn_t'{addr_w[i], wstrb_w[i], wdata_w[i]};
            log_rise[i][n_log[i]] <= (hi_run[i] == 0) ? cyc : rise_cyc[i];
            log_end[i][n_log[i]]  <= cyc;
            n_log[i] <= n_log[i] + 1;
            if (addr_w[i] == ADDR_SR) n_sr[i] <= n_sr[i] + 1;
         end
      end
   end

   int   n_cmp = 0;
   int   n_mis = 0;
   txn_t exp_q [$];
   vec_t vecs [6];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
      n_cmp++;
      if (act !== req) begin
         n_mis++;
         $display("FAIL %s: got %h, expected %h", name, act, req);
      end
   endtask

   task automatic push_seq(input int n_setup, input int nsr, input logic tail, input logic cr0w);
      if (n_setup > 0) begin
         exp_q.push_back(txn_t'{ADDR_TR, 4'hF, 32'h0432_220A});
         exp_q.push_back(txn_t'{ADDR_CR, 4'hF, 32'h0000_0031});
      end
      for (int k = 0; k < nsr; k++) exp_q.push_back(txn_t'{ADDR_SR, 4'h0, 32'h0});
      if (tail) begin
         exp_q.push_back(txn_t'{ADDR_ID0, 4'h0, 32'h0});
         exp_q.push_back(txn_t'{ADDR_CR0, 4'h0, 32'h0});
         if (cr0w) exp_q.push_back(txn_t'{ADDR_CR0, 4'hF, 32'h70E0_8F1F});
      end
   endtask

   task automatic drain(input int d, input int base, input string name);
      chk($sformatf("%s txn count", name), n_log[d] - base, exp_q.size());
      for (int k = base; k < n_log[d] && exp_q.size() > 0; k++) begin
         txn_t e;
         e = exp_q.pop_front();
         chk($sformatf("%s txn%0d addr", name, k - base), 32'(log_txn[d][k].addr), 32'(e.addr));
         chk($sformatf("%s txn%0d wstrb", name, k - base), 32'(log_txn[d][k].wstrb),
             32'(e.wstrb));
         if (e.wstrb == 4'hF)
            chk($sformatf("%s txn%0d wdata", name, k - base), log_txn[d][k].wdata, e.wdata);
      end
      exp_q.delete();
   endtask

   task automatic pulse(input int d);
      @(negedge clk);
      start_v[d] = 1'b1;
      @(negedge clk);
      start_v[d] = 1'b0;
   endtask

   task automatic wait_end(input int d, input string name);
      int n;
      n = 0;
      while (!(done_w[d] || err_w[d]) && n < 30000) begin
         @(negedge clk);
         n++;
      end
      if (n >= 30000) begin
         n_cmp++;
         n_mis++;
         $display("FAIL %s end: got no done/err after %0d cycles, expected done or err", name, n);
      end
      @(negedge clk);
   endtask

   task automatic chk_reset(input int d, input string name);
      chk({name, " valid"}, 32'(valid_w[d]), 32'd0);
      chk({name, " addr"}, 32'(addr_w[d]), 32'd0);
      chk({name, " wdata"}, wdata_w[d], 32'd0);
      chk({name, " wstrb"}, 32'(wstrb_w[d]), 32'd0);
      chk({name, " busy/done/err"}, 32'({busy_w[d], done_w[d], err_w[d]}), 32'd0);
      chk({name, " err_code"}, 32'(code_w[d]), 32'd0);
      chk({name, " id0"}, 32'(id0_w[d]), 32'd0);
      chk({name, " cr0"}, 32'(cr0_w[d]), 32'd0);
   endtask

   task automatic run_vec(input vec_t v, input int idx);
      int    d;
      int    base;
      string name;
      d    = v.dut;
      name = $sformatf("vec%0d", idx);
      stall_v[d]   = v.stall;
      srerr_v[d]   = v.sr_err;
      id0_model[d] = v.id0v;
      rdy_after[d] = n_sr[d] + v.not_rdy;
      base = n_log[d];
      push_seq(v.n_setup, v.n_sr, v.tail, v.cr0w);
      pulse(d);
      wait_end(d, name);
      chk({name, " done"}, 32'(done_w[d]), 32'(v.exp_done));
      chk({name, " err"}, 32'(err_w[d]), 32'(v.exp_err));
      chk({name, " err_code"}, 32'(code_w[d]), 32'(v.exp_code));
      chk({name, " busy"}, 32'(busy_w[d]), 32'd0);
      if (v.tail) begin
         chk({name, " id0"}, 32'(id0_w[d]), 32'(v.id0v));
         chk({name, " cr0"}, 32'(cr0_w[d]), CR0_RB);
      end
      if (v.stall) chk({name, " valid high cycles"}, last_hi[d], 32'd64);
      for (int k = base + 1; k < n_log[d]; k++) begin
         if (log_txn[d][k].addr == ADDR_SR && log_txn[d][k-1].addr == ADDR_SR)
            chk($sformatf("%s poll gap>=16 (gap %0d)", name, log_rise[d][k] - log_end[d][k-1] - 1),
                32'(log_rise[d][k] - log_end[d][k-1] - 1 >= 16), 32'd1);
      end
      drain(d, base, name);
   endtask

   initial begin
      int base;
      int n;
      // dut, not_rdy, sr_err, stall, id0, done, err, code, setup, n_sr, tail, cr0w
      vecs[0] = '{0, 0,    1'b0, 1'b0, 16'h1234, 1'b1, 1'b0, 2'd0, 2, 1, 1'b1, 1'b1};
      vecs[1] = '{0, 3,    1'b0, 1'b0, 16'h5A5A, 1'b1, 1'b0, 2'd0, 2, 4, 1'b1, 1'b1};
      vecs[2] = '{0, 0,    1'b1, 1'b0, 16'h1111, 1'b0, 1'b1, 2'd2, 2, 1, 1'b0, 1'b0};
      vecs[3] = '{0, 0,    1'b0, 1'b1, 16'h0000, 1'b0, 1'b1, 2'd1, 0, 0, 1'b0, 1'b0};
      vecs[4] = '{1, 1000, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b1, 2'd3, 2, 4, 1'b0, 1'b0};
      vecs[5] = '{1, 0,    1'b0, 1'b0, 16'h0C81, 1'b1, 1'b0, 2'd0, 2, 1, 1'b1, 1'b0};

      repeat (3) @(negedge clk);
      chk_reset(0, "por a");
      chk_reset(1, "por b");
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

      // Restart after done, with stray starts while busy (one in a ready cycle).
      rdy_after[1] = n_sr[1];
      base = n_log[1];
      push_seq(2, 1, 1'b1, 1'b0);
      pulse(1);
      chk("restart done clears", 32'(done_w[1]), 32'd0);
      chk("restart busy", 32'(busy_w[1]), 32'd1);
      n = 0;
      while (!(valid_w[1] && ready_w[1]) && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("restart ready seen", 32'(n < 100), 32'd1);
      start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      repeat (3) @(negedge clk);
      start_v[1] = 1'b1;
      @(negedge clk);
      start_v[1] = 1'b0;
      wait_end(1, "restart");
      chk("restart done", 32'(done_w[1]), 32'd1);
      chk("restart busy end", 32'(busy_w[1]), 32'd0);
      chk("restart id0", 32'(id0_w[1]), 32'h0C81);
      drain(1, base, "restart");

      // Asynchronous reset in the middle of the TR write.
      rdy_after[1] = n_sr[1];
      pulse(1);
      n = 0;
      while (!valid_w[1] && n < 100) begin
         @(negedge clk);
         n++;
      end
      chk("midreset valid seen", 32'(valid_w[1]), 32'd1);
      rst_n = 1'b0;
      #1;
      chk_reset(1, "midreset");
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
